// File: rtl/fpu_sequencer.sv
// fpu_sequencer: multicycle issue/sequencing stage in front of the combinational
// FP helper units. Registers and conditions operands, waits a per-op latency,
// then qualifies the helper output and emits a one-cycle done/writeback pulse.
// Ports: clk/rst_n (sync active-low); start/opcode/fs/ft from decode; flag_clr;
//        op_a/op_b to helpers; *_res from helpers; busy/done/wb_en/result/fcc/dz_flag.
module fpu_sequencer #(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CVT_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  opcode,
  input  logic [31:0] fs,
  input  logic [31:0] ft,
  input  logic        flag_clr,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] addsub_res,
  input  logic [31:0] mul_res,
  input  logic [31:0] div_res,
  input  logic [31:0] cvt_res,
  input  logic [31:0] ceq_res,
  input  logic [31:0] clt_res,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [31:0] result,
  output logic        fcc,
  output logic        dz_flag
);

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
                         OP_CVT = 3'd4, OP_CEQ = 3'd5, OP_CLT = 3'd6;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [2:0]  opc, opc_nxt;
  logic [31:0] op_a_nxt, op_b_nxt, result_nxt;
  logic        done_nxt, wb_en_nxt, fcc_nxt, dz_nxt;
  logic [3:0]  lat_m1;
  logic        za, zb, sgn;

  // Only bit 0 of the compare helpers carries information.
  logic unused_ok;
  assign unused_ok = &{1'b0, ceq_res[31:1], clt_res[31:1]};

  assign busy = (state == EXEC);

  // Zero test ignores the sign so that +0 and -0 are both special-cased.
  assign za  = (op_a[30:0] == 31'd0);
  assign zb  = (op_b[30:0] == 31'd0);
  assign sgn = op_a[31] ^ op_b[31];

  always_comb begin
    lat_m1 = 4'd0;
    case (opcode)
      OP_ADD, OP_SUB: lat_m1 = 4'(ADD_LAT - 1);
      OP_MUL:         lat_m1 = 4'(MUL_LAT - 1);
      OP_DIV:         lat_m1 = 4'(DIV_LAT - 1);
      OP_CVT:         lat_m1 = 4'(CVT_LAT - 1);
      default:        lat_m1 = 4'd0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    opc_nxt    = opc;
    op_a_nxt   = op_a;
    op_b_nxt   = op_b;
    result_nxt = result;
    fcc_nxt    = fcc;
    done_nxt   = 1'b0;
    wb_en_nxt  = 1'b0;
    // Clear is applied first so a divide-by-zero on the same edge overrides it.
    dz_nxt     = flag_clr ? 1'b0 : dz_flag;

    case (state)
      IDLE: begin
        if (start) begin
          opc_nxt   = opcode;
          op_a_nxt  = fs;
          // Subtraction reuses the adder by flipping the sign of operand B.
          op_b_nxt  = (opcode == OP_SUB) ? {~ft[31], ft[30:0]} : ft;
          cnt_nxt   = lat_m1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          wb_en_nxt = (opc != OP_CEQ) && (opc != OP_CLT);
          case (opc)
            OP_ADD, OP_SUB: begin
              if (za)      result_nxt = op_b;
              else if (zb) result_nxt = op_a;
              else         result_nxt = addsub_res;
            end
            OP_MUL: result_nxt = (za || zb) ? {sgn, 31'd0} : mul_res;
            OP_DIV: begin
              if (zb) begin
                result_nxt = {sgn, 8'hFF, 23'd0};
                dz_nxt     = 1'b1;
              end else if (za) begin
                result_nxt = {sgn, 31'd0};
              end else begin
                result_nxt = div_res;
              end
            end
            OP_CVT: result_nxt = za ? 32'd0 : cvt_res;
            OP_CEQ: fcc_nxt = ceq_res[0];
            OP_CLT: fcc_nxt = clt_res[0];
            default: result_nxt = op_a;
          endcase
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      opc     <= 3'd0;
      op_a    <= 32'd0;
      op_b    <= 32'd0;
      result  <= 32'd0;
      done    <= 1'b0;
      wb_en   <= 1'b0;
      fcc     <= 1'b0;
      dz_flag <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      opc     <= opc_nxt;
      op_a    <= op_a_nxt;
      op_b    <= op_b_nxt;
      result  <= result_nxt;
      done    <= done_nxt;
      wb_en   <= wb_en_nxt;
      fcc     <= fcc_nxt;
      dz_flag <= dz_nxt;
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: randomized + directed stimulus against a behavioural model;
// expectations are queued at issue and checked by an independent monitor on done.
// Ports: drives every fpu_sequencer port; helper results are supplied by the bench.
module tb_fpu_sequencer;
  localparam int ADD_LAT = 2, MUL_LAT = 3, DIV_LAT = 8, CVT_LAT = 2;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flag_clr = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic [31:0] fs = 32'd0, ft = 32'd0;
  logic [31:0] addsub_res = 32'd0, mul_res = 32'd0, div_res = 32'd0;
  logic [31:0] cvt_res = 32'd0, ceq_res = 32'd0, clt_res = 32'd0;
  logic [31:0] op_a, op_b, result;
  logic        busy, done, wb_en, fcc, dz_flag;

  fpu_sequencer #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CVT_LAT(CVT_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .fs(fs), .ft(ft),
    .flag_clr(flag_clr), .op_a(op_a), .op_b(op_b), .addsub_res(addsub_res),
    .mul_res(mul_res), .div_res(div_res), .cvt_res(cvt_res), .ceq_res(ceq_res),
    .clt_res(clt_res), .busy(busy), .done(done), .wb_en(wb_en), .result(result),
    .fcc(fcc), .dz_flag(dz_flag));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res, opa, opb;
    logic        wb, fcc, dz;
    int          acc, lat;
  } exp_t;
  exp_t q[$];

  int pass_cnt = 0, tot_cnt = 0;
  // Architectural state of the reference model.
  logic [31:0] m_res = 32'd0;
  logic        m_fcc = 1'b0, m_dz = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tot_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
  endtask

  function automatic bit iszero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  // Reference model: applies the operation rules directly to the decode-time operands.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    logic [31:0] bb;
    logic        s;
    bb = (op == 3'd1) ? (b ^ 32'h8000_0000) : b;
    s  = a[31] ^ bb[31];
    case (op)
      3'd0, 3'd1: m_res = iszero(a) ? bb : (iszero(bb) ? a : addsub_res);
      3'd2: m_res = (iszero(a) || iszero(bb)) ? {s, 31'd0} : mul_res;
      3'd3: begin
        if (iszero(bb)) begin m_res = {s, 8'hFF, 23'd0}; m_dz = 1'b1; end
        else if (iszero(a)) m_res = {s, 31'd0};
        else m_res = div_res;
      end
      3'd4: m_res = iszero(a) ? 32'd0 : cvt_res;
      3'd5: m_fcc = ceq_res[0];
      3'd6: m_fcc = clt_res[0];
      default: m_res = a;
    endcase
    e.res = m_res; e.fcc = m_fcc; e.dz = m_dz;
    e.opa = a; e.opb = bb;
    e.wb  = !(op == 3'd5 || op == 3'd6);
    case (op)
      3'd0, 3'd1: e.lat = ADD_LAT;
      3'd2:       e.lat = MUL_LAT;
      3'd3:       e.lat = DIV_LAT;
      3'd4:       e.lat = CVT_LAT;
      default:    e.lat = 1;
    endcase
    e.acc = 0;
  endtask

  // Called at a negedge with the DUT not busy; returns at the done-cycle negedge
  // (or right after the accept when wait_done=0).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h_add, input logic [31:0] h_mul, input logic [31:0] h_div,
                       input logic [31:0] h_cvt, input logic [31:0] h_eq, input logic [31:0] h_lt,
                       input bit junk, input bit wait_done);
    exp_t e;
    bit   ok;
    addsub_res = h_add; mul_res = h_mul; div_res = h_div;
    cvt_res = h_cvt; ceq_res = h_eq; clt_res = h_lt;
    opcode = op; fs = a; ft = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model(op, a, b, e);
    e.acc = cyc;
    q.push_back(e);
    chk("op_a_latched", op_a, e.opa);
    chk("op_b_latched", op_b, e.opb);
    if (wait_done) begin
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        if (!busy) begin
          start = 1'b0; ok = 1'b1;
        end else begin
          // Garbage requests while busy must be ignored.
          start  = junk && ($urandom_range(0, 1) == 1);
          opcode = 3'($urandom_range(0, 7));
          fs     = $urandom;
          ft     = $urandom;
        end
      end
      if (!ok) chk("done_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic clr_flag;
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    m_dz = 1'b0;
    chk("dz_cleared", {31'd0, dz_flag}, 32'd0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_operand;
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) == 0) v = {v[31], 31'd0};
    return v;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", result, e.res);
          chk("wb_en", {31'd0, wb_en}, {31'd0, e.wb});
          chk("fcc", {31'd0, fcc}, {31'd0, e.fcc});
          chk("dz_flag", {31'd0, dz_flag}, {31'd0, e.dz});
          chk("busy_in_done", {31'd0, busy}, 32'd0);
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("op_a_stable", op_a, e.opa);
          chk("op_b_stable", op_b, e.opb);
        end
      end else begin
        chk("wb_en_idle", {31'd0, wb_en}, 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_op_a"}, op_a, 32'd0);
    chk({tag, "_op_b"}, op_b, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_flags"}, {26'd0, busy, done, wb_en, fcc, dz_flag, 1'b0}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // add 1.5 + 2.0 = 3.5
    issue(3'd0, 32'h3FC00000, 32'h40000000, 32'h40600000, 0, 0, 0, 0, 0, 0, 1);
    // sub 3.5 - 2.0: op_b is presented as -2.0
    issue(3'd1, 32'h40600000, 32'h40000000, 32'h3FC00000, 0, 0, 0, 0, 0, 0, 1);
    // mul by zero overrides the helper
    issue(3'd2, 32'h00000000, 32'hC0000000, 0, 32'h12345678, 0, 0, 0, 0, 0, 1);
    // divide by zero -> +inf, sticky flag
    issue(3'd3, 32'h3F800000, 32'h00000000, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1, 1);
    issue(3'd7, 32'h40400000, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("dz_sticky", {31'd0, dz_flag}, 32'd1);
    clr_flag();
    // c.lt then back-to-back c.eq
    issue(3'd6, 32'h3FC00000, 32'h40000000, 0, 0, 0, 0, 0, 32'h1, 0, 1);
    issue(3'd5, 32'h40000000, 32'h40000000, 0, 0, 0, 0, 32'h1, 0, 0, 1);

    for (int n = 0; n < 150; n++) begin
      issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 2) == 0, 1);
      if ($urandom_range(0, 9) == 0) clr_flag();
    end

    // Reset in the middle of a divide: no done pulse, everything cleared.
    issue(3'd3, 32'h40000000, 32'h3F800000, 0, 0, 32'h40000000, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("abort");
    q.delete();
    m_res = 32'd0; m_fcc = 1'b0; m_dz = 1'b0;
    rst_n = 1'b1;
    repeat (DIV_LAT + 4) @(negedge clk);

    // Recovery after the abort.
    issue(3'd4, 32'h41200000, 32'h0, 0, 0, 0, 32'h0000000A, 0, 0, 1, 1);
    issue(3'd2, 32'h40000000, 32'h40400000, 0, 32'h40C00000, 0, 0, 0, 0, 0, 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
